// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-request responder driving a word-wide RAM port.
// Optional LL/SC link tracking is compiled in when DMEM_LLSC_EN is defined.
module dmem_responder #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        datomic,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        derror,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;
  logic          r_wr, w_wr_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_data, w_data_nxt;
  logic [DW-1:0] r_dload, w_dload_nxt;

  logic          r_dhit, w_dhit_nxt;
  logic          r_derror, w_derror_nxt;
  logic          r_ramren, w_ramren_nxt;
  logic          r_ramwen, w_ramwen_nxt;
  logic [DW-1:0] r_ramaddr, w_ramaddr_nxt;
  logic [DW-1:0] r_ramstore, w_ramstore_nxt;

`ifdef DMEM_LLSC_EN
  logic          r_atom, w_atom_nxt;
  logic          r_link_vld, w_link_vld_nxt;
  logic [AW-1:0] r_link_addr, w_link_addr_nxt;
  logic          w_link_hit;
  logic          w_ll_set;
  assign w_link_hit = r_link_vld && (r_link_addr == daddr[31:2]);
`endif

  // Byte offsets never reach the word-wide RAM; snoop/atomic only matter with LL/SC.
  logic w_unused;
  assign w_unused = ^{datomic, snoop_valid, snoop_addr, daddr[1:0]};

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_dload    <= '0;
      r_dhit     <= 1'b0;
      r_derror   <= 1'b0;
      r_ramren   <= 1'b0;
      r_ramwen   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
`ifdef DMEM_LLSC_EN
      r_atom      <= 1'b0;
      r_link_vld  <= 1'b0;
      r_link_addr <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_wr       <= w_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_dload    <= w_dload_nxt;
      r_dhit     <= w_dhit_nxt;
      r_derror   <= w_derror_nxt;
      r_ramren   <= w_ramren_nxt;
      r_ramwen   <= w_ramwen_nxt;
      r_ramaddr  <= w_ramaddr_nxt;
      r_ramstore <= w_ramstore_nxt;
`ifdef DMEM_LLSC_EN
      r_atom      <= w_atom_nxt;
      r_link_vld  <= w_link_vld_nxt;
      r_link_addr <= w_link_addr_nxt;
`endif
    end
  end

  // Next-state, request latch, completion data and link tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_dload_nxt = r_dload;
`ifdef DMEM_LLSC_EN
    w_atom_nxt      = r_atom;
    w_link_vld_nxt  = r_link_vld;
    w_link_addr_nxt = r_link_addr;
    w_ll_set        = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (dWEN || dREN) begin
          w_wr_nxt    = dWEN;
          w_addr_nxt  = daddr[31:2];
          w_data_nxt  = dstore;
          w_state_nxt = S_ACCESS;
`ifdef DMEM_LLSC_EN
          w_atom_nxt = datomic;
          if (dWEN && datomic) begin
            w_link_vld_nxt = 1'b0;
            // A failed SC completes without touching RAM.
            if (!w_link_hit) begin
              w_state_nxt = S_DONE;
              w_dload_nxt = '0;
            end
          end else if (dWEN && w_link_hit) begin
            w_link_vld_nxt = 1'b0;
          end
`endif
        end
      end
      S_ACCESS: begin
        if (ramstate == RS_ACCESS) begin
          w_state_nxt = S_DONE;
          w_dload_nxt = r_wr ? '0 : ramload;
`ifdef DMEM_LLSC_EN
          if (r_atom && r_wr) begin
            w_dload_nxt = DW'(1);
          end
          if (r_atom && !r_wr) begin
            w_link_vld_nxt  = 1'b1;
            w_link_addr_nxt = r_addr;
            w_ll_set        = 1'b1;
          end
`endif
        end else if ((ramstate == RS_ERROR) || (r_cnt == TMAX)) begin
          w_state_nxt = S_DONE;
          w_dload_nxt = ERR_WORD;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_err_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
`ifdef DMEM_LLSC_EN
    if (snoop_valid && (snoop_addr[31:2] == r_link_addr) && !w_ll_set) begin
      w_link_vld_nxt = 1'b0;
    end
`endif
  end

  // Output decode of the upcoming state.
  always_comb begin
    w_dhit_nxt     = 1'b0;
    w_derror_nxt   = 1'b0;
    w_ramren_nxt   = 1'b0;
    w_ramwen_nxt   = 1'b0;
    w_ramaddr_nxt  = '0;
    w_ramstore_nxt = '0;
    case (w_state_nxt)
      S_ACCESS: begin
        w_ramren_nxt   = !w_wr_nxt;
        w_ramwen_nxt   = w_wr_nxt;
        w_ramaddr_nxt  = {w_addr_nxt, 2'b00};
        w_ramstore_nxt = w_data_nxt;
      end
      S_DONE: begin
        w_dhit_nxt   = 1'b1;
        w_derror_nxt = w_err_nxt;
      end
      default: begin
      end
    endcase
  end

  assign dhit     = r_dhit;
  assign derror   = r_derror;
  assign dload    = r_dload;
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (TIMEOUT=4); LL/SC steps follow DMEM_LLSC_EN.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST, dREN, dWEN, datomic, snoop_valid;
  logic [31:0] daddr, dstore, snoop_addr, ramload;
  logic [1:0]  ramstate;
  logic        dhit, derror, ramREN, ramWEN;
  logic [31:0] dload, ramaddr, ramstore;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2;

  dmem_responder #(.TIMEOUT(4), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .datomic(datomic), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .dhit(dhit), .dload(dload), .derror(derror), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramstate(ramstate), .ramload(ramload)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int  strobes;
  bit  seen;

  initial begin
    RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; snoop_valid = 1'b0;
    daddr = '0; dstore = '0; snoop_addr = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_derror", 32'(derror), 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    RST = 1'b0;
    tick();

    // Read 0x104, RAM answers on the first access cycle.
    dREN = 1'b1; daddr = 32'h104;
    tick();
    chk("rd_ramren", 32'(ramREN), 32'd1);
    chk("rd_ramwen", 32'(ramWEN), 32'd0);
    chk("rd_ramaddr", ramaddr, 32'h104);
    chk("rd_nohit_early", 32'(dhit), 32'd0);
    ramstate = ACC; ramload = 32'hCAFEF00D;
    tick();
    chk("rd_dhit", 32'(dhit), 32'd1);
    chk("rd_dload", dload, 32'hCAFEF00D);
    chk("rd_derror", 32'(derror), 32'd0);
    chk("rd_ramren_off", 32'(ramREN), 32'd0);
    dREN = 1'b0; ramstate = FREE;
    tick();
    chk("rd_dhit_once", 32'(dhit), 32'd0);
    chk("rd_dload_hold", dload, 32'hCAFEF00D);

    // Write 0x203 with three BUSY cycles before ACCESS.
    dWEN = 1'b1; daddr = 32'h203; dstore = 32'h12345678;
    tick();
    chk("wr_ramaddr", ramaddr, 32'h200);
    chk("wr_ramstore", ramstore, 32'h12345678);
    ramstate = BUSY;
    for (int i = 0; i < 3; i++) begin
      chk("wr_ramwen_held", 32'(ramWEN), 32'd1);
      chk("wr_nohit_busy", 32'(dhit), 32'd0);
      tick();
    end
    chk("wr_ramwen_4th", 32'(ramWEN), 32'd1);
    ramstate = ACC;
    tick();
    chk("wr_dhit", 32'(dhit), 32'd1);
    chk("wr_dload", dload, 32'd0);
    chk("wr_ramwen_off", 32'(ramWEN), 32'd0);
    dWEN = 1'b0; ramstate = FREE;
    tick();
    chk("wr_dhit_once", 32'(dhit), 32'd0);

    // dREN and dWEN together: write wins.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5A5A5; ramload = 32'h77777777;
    tick();
    chk("both_ramwen", 32'(ramWEN), 32'd1);
    chk("both_ramren", 32'(ramREN), 32'd0);
    ramstate = ACC;
    tick();
    chk("both_dhit", 32'(dhit), 32'd1);
    chk("both_dload", dload, 32'd0);
    chk("both_ramren_done", 32'(ramREN), 32'd0);
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();

    // Timeout: RAM stuck BUSY.
    dREN = 1'b1; daddr = 32'h10; ramstate = BUSY;
    tick();
    seen = 1'b0; strobes = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dhit) seen = 1'b1;
      else begin
        if (ramREN) strobes++;
        tick();
      end
    end
    chk("to_dhit_seen", 32'(seen), 32'd1);
    chk("to_wait_cycles", 32'(strobes), 32'd4);
    chk("to_derror", 32'(derror), 32'd1);
    chk("to_dload", dload, 32'hBAD1BAD1);
    dREN = 1'b0; ramstate = FREE;
    tick();
    chk("to_derror_once", 32'(derror), 32'd0);
    dREN = 1'b1; daddr = 32'h20;
    tick();
    ramstate = ACC; ramload = 32'h0000_55AA;
    tick();
    chk("to_next_dhit", 32'(dhit), 32'd1);
    chk("to_next_dload", dload, 32'h0000_55AA);
    chk("to_next_derror", 32'(derror), 32'd0);
    dREN = 1'b0; ramstate = FREE;
    tick();

    // Reset in the middle of an access.
    dREN = 1'b1; daddr = 32'h44; ramstate = BUSY;
    tick();
    chk("rstm_ramren", 32'(ramREN), 32'd1);
    RST = 1'b1; dREN = 1'b0; ramstate = ACC; ramload = 32'hDEADBEEF;
    tick();
    chk("rstm_dhit", 32'(dhit), 32'd0);
    chk("rstm_ramren", 32'(ramREN), 32'd0);
    chk("rstm_dload", dload, 32'd0);
    chk("rstm_ramaddr", ramaddr, 32'd0);
    RST = 1'b0; ramstate = FREE;
    tick();
    chk("rstm_no_hit", 32'(dhit), 32'd0);
    dREN = 1'b1; daddr = 32'h48;
    tick();
    chk("rstm_new_ramaddr", ramaddr, 32'h48);
    ramstate = ACC; ramload = 32'h13579BDF;
    tick();
    chk("rstm_new_dhit", 32'(dhit), 32'd1);
    chk("rstm_new_dload", dload, 32'h13579BDF);
    dREN = 1'b0; ramstate = FREE;
    tick();

`ifdef DMEM_LLSC_EN
    // LL 0x40 then SC 0x40 succeeds.
    dREN = 1'b1; datomic = 1'b1; daddr = 32'h40;
    tick();
    ramstate = ACC; ramload = 32'h11;
    tick();
    chk("ll_dload", dload, 32'h11);
    dREN = 1'b0; ramstate = FREE;
    tick();
    dWEN = 1'b1; dstore = 32'h99;
    tick();
    chk("sc_ok_ramwen", 32'(ramWEN), 32'd1);
    ramstate = ACC;
    tick();
    chk("sc_ok_dhit", 32'(dhit), 32'd1);
    chk("sc_ok_dload", dload, 32'd1);
    dWEN = 1'b0; ramstate = FREE;
    tick();
    // LL 0x40, snoop 0x40, SC fails without RAM access.
    dREN = 1'b1; ramload = 32'h22;
    tick();
    ramstate = ACC;
    tick();
    chk("ll2_dload", dload, 32'h22);
    dREN = 1'b0; ramstate = FREE; snoop_valid = 1'b1; snoop_addr = 32'h40;
    tick();
    snoop_valid = 1'b0;
    dWEN = 1'b1; dstore = 32'h55;
    tick();
    chk("sc_fail_dhit", 32'(dhit), 32'd1);
    chk("sc_fail_ramwen", 32'(ramWEN), 32'd0);
    chk("sc_fail_dload", dload, 32'd0);
    dWEN = 1'b0; datomic = 1'b0;
    tick();
`else
    // Without LL/SC an atomic store is a plain write.
    dWEN = 1'b1; datomic = 1'b1; daddr = 32'h40; dstore = 32'h99; snoop_valid = 1'b1; snoop_addr = 32'h40;
    tick();
    chk("sc_plain_ramwen", 32'(ramWEN), 32'd1);
    chk("sc_plain_ramstore", ramstore, 32'h99);
    ramstate = ACC;
    tick();
    chk("sc_plain_dhit", 32'(dhit), 32'd1);
    chk("sc_plain_dload", dload, 32'd0);
    dWEN = 1'b0; datomic = 1'b0; snoop_valid = 1'b0; ramstate = FREE;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-request interface, i.e. the lines driven out of the execute/memory latch: dREN, dWEN, daddr, dstore.
- Accepts one request at a time and drives the word-wide RAM port until RAM reports ACCESS.
- Returns a single-cycle registered dhit with dload.
- Sits between the datapath memory stage and the RAM / memory-control port of one core.

Parameters:
- TIMEOUT, 64: max cycles waiting for RAM ACCESS before forced error completion; 2..1023.
- ERR_WORD, 32'hBAD1BAD1: dload value returned on error completion.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- dREN  in  1  data read request, level, held until dhit
- dWEN  in  1  data write request, level, held until dhit
- daddr  in  32  byte address
- dstore  in  32  write data
- datomic  in  1  LL (with dREN) / SC (with dWEN) qualifier
- snoop_valid  in  1  another core's write is visible this cycle
- snoop_addr  in  32  address of that write
- dhit  out  1  one-cycle completion pulse
- dload  out  32  read data / SC result, valid while dhit=1
- derror  out  1  one-cycle pulse with dhit when completion is an error
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  word-aligned RAM address
- ramstore  out  32  RAM write data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramload  in  32  RAM read data, valid when ramstate=ACCESS

Behaviour:
- Reset (RST high at a CLK edge, at any point incl. mid-access):
  - state=IDLE; all outputs 0; timeout counter 0; link register invalid.
  - An in-flight RAM access is abandoned and produces no dhit.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If dWEN=1, accept a write; dWEN has priority, so dREN is ignored when both are high.
  - Else if dREN=1, accept a read.
  - On acceptance, latch {op, daddr[31:2], dstore, datomic} and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - ramaddr={latched[31:2],2'b00}; ramREN/ramWEN asserted from the latched op, exactly one high; ramstore=latched data.
  - Request inputs are ignored while in ACCESS.
  - ramstate=ACCESS: capture ramload (read) or 0 (write) into dload; go to DONE.
  - ramstate=ERROR: dload=ERR_WORD, set error flag; go to DONE.
  - FREE/BUSY: increment the counter. When the counter reaches TIMEOUT-1 without ACCESS, complete as error.
- DONE:
  - dhit=1 for exactly this cycle; derror=error flag; ram strobes 0.
  - Next state IDLE; counter and error flag cleared.
  - dload holds its value until the next completion.
- Minimum latency: request seen in IDLE at cycle 0, RAM ACCESS at cycle 1, dhit at cycle 2.
- The requester drops dREN/dWEN on the edge ending the dhit cycle, so IDLE never re-accepts a completed request.
  - If the request is still high in IDLE, it is treated as new; this is legal back-to-back use.
- Only one outstanding request; no buffering.
- A snoop with no LL/SC feature compiled in has no effect.

Optional Feature:
- Macro: DMEM_LLSC_EN.
- With the macro, a link register {valid, addr[31:2]} is kept:
  - LL (dREN and datomic) sets the link to the latched address on completion.
  - SC (dWEN and datomic) with valid link and matching address performs the RAM write; dload=1 at dhit; link cleared.
  - SC with no valid link or a mismatched address does no RAM access: ACCESS is skipped, DONE follows IDLE directly (dhit one cycle after acceptance), dload=0, link cleared.
  - A plain write to the linked word clears the link at acceptance.
  - snoop_valid with snoop_addr[31:2] equal to the link address clears the link. If this coincides with LL completion, the LL set wins.
- Without the macro: datomic is ignored; SC behaves as a plain write with dload=0; snoop ports are unused.

Test Plan:
- Read daddr=0x104, RAM answers ACCESS first cycle with ramload=0xCAFEF00D -> ramREN=1 and ramaddr=0x104 for 1 cycle; dhit=1 two cycles after request with dload=0xCAFEF00D; derror=0.
- Write daddr=0x203, dstore=0x12345678, ramstate BUSY 3 cycles then ACCESS -> ramaddr=0x200, ramWEN held 4 cycles, dhit once, dload=0.
- dREN=dWEN=1 simultaneously -> write performed only; ramREN never asserted.
- TIMEOUT=4, ramstate stuck BUSY -> dhit and derror pulse together, dload=0xBAD1BAD1; next request served normally.
- RST asserted in ACCESS -> next cycle all outputs 0, no dhit; a new read then completes normally.
- With DMEM_LLSC_EN:
  - LL 0x40 then SC 0x40 -> RAM write and dload=1.
  - LL 0x40, snoop_addr=0x40, then SC -> no ramWEN, dhit next cycle, dload=0.
